// File: rtl/icache_pkg.sv
// Shared geometry, AHB encodings and refill FSM state type for the
// instruction-cache refill controller.
package icache_pkg;

  localparam int CACHE_LINE = 128;
  localparam int CACHE_SIZE = 8192;
  localparam int INDEX_W    = $clog2(CACHE_SIZE * 8 / CACHE_LINE);
  localparam int OFS_W      = 2;
  localparam int TAG_W      = 32 - INDEX_W - OFS_W;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_BEAT,
    ST_FILL,
    ST_ERR
  } refill_state_t;

endpackage

// File: rtl/icache_line_buf.sv
// Four-word line assembly buffer: one 32-bit word written per cycle into a
// 2-bit slot, whole line visible on the output.
module icache_line_buf
  import icache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [1:0]            i_slot,
  input  logic [31:0]           i_wdata,
  output logic [CACHE_LINE-1:0] o_line
);

  logic [31:0] r_word [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_word[i] <= '0;
    end else if (i_we) begin
      r_word[i_slot] <= i_wdata;
    end
  end

  assign o_line = {r_word[3], r_word[2], r_word[1], r_word[0]};

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller: fetches one line as an AHB WRAP4 read
// burst, critical word first, and writes the assembled line to the array.
//
// state | meaning
// IDLE  | ready for a miss request
// ADDR  | beat 0 address phase (NONSEQ)
// BEAT  | pipelined address/data phases for the rest of the burst
// FILL  | one-cycle line write to the array
// ERR   | bus error seen, one-cycle error pulse
module icache_refill_ctrl
  import icache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  input  logic [31:0]           miss_addr,
  output logic                  miss_ready,
  output logic [31:0]           haddr,
  output logic [1:0]            htrans,
  output logic [2:0]            hburst,
  output logic [2:0]            hsize,
  output logic                  hwrite,
  input  logic                  hready,
  input  logic                  hresp,
  input  logic [31:0]           hrdata,
  output logic                  crit_valid,
  output logic [31:0]           crit_data,
  output logic                  line_we,
  output logic [INDEX_W-1:0]    line_index,
  output logic [TAG_W-1:0]      line_tag,
  output logic [CACHE_LINE-1:0] line_data,
  output logic                  refill_err
);

  refill_state_t r_state, w_next;
  logic [31:0]   r_addr;
  logic [2:0]    r_addr_cnt;
  logic [1:0]    r_data_cnt;
  logic          r_crit_valid;
  logic [31:0]   r_crit_data;

  logic          w_data_acc;
  logic [1:0]    w_aslot;
  logic [1:0]    w_wslot;

  // In BEAT exactly one data phase is always outstanding.
  assign w_data_acc = (r_state == ST_BEAT) && hready && !hresp;
  assign w_aslot    = r_addr[1:0] + r_addr_cnt[1:0];
  assign w_wslot    = r_addr[1:0] + r_data_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_addr_cnt   <= '0;
      r_data_cnt   <= '0;
      r_crit_valid <= 1'b0;
      r_crit_data  <= '0;
    end else begin
      r_state      <= w_next;
      r_crit_valid <= w_data_acc && (r_data_cnt == 2'd0);
      if (w_data_acc && (r_data_cnt == 2'd0)) r_crit_data <= hrdata;
      if (r_state == ST_IDLE && miss_valid) begin
        r_addr     <= miss_addr;
        r_addr_cnt <= '0;
        r_data_cnt <= '0;
      end
      if (r_state == ST_ADDR && hready) r_addr_cnt <= 3'd1;
      if (w_data_acc) begin
        r_data_cnt <= r_data_cnt + 2'd1;
        if (r_addr_cnt < 3'd4) r_addr_cnt <= r_addr_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    miss_ready = 1'b0;
    haddr      = '0;
    htrans     = HTRANS_IDLE;
    hburst     = HBURST_SINGLE;
    hsize      = HSIZE_BYTE;
    line_we    = 1'b0;
    refill_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) w_next = ST_ADDR;
      end
      ST_ADDR: begin
        htrans = HTRANS_NONSEQ;
        haddr  = {r_addr[29:2], w_aslot, 2'b00};
        hburst = HBURST_WRAP4;
        hsize  = HSIZE_WORD;
        if (hready) w_next = ST_BEAT;
      end
      ST_BEAT: begin
        htrans = (r_addr_cnt < 3'd4) ? HTRANS_SEQ : HTRANS_IDLE;
        haddr  = {r_addr[29:2], w_aslot, 2'b00};
        hburst = HBURST_WRAP4;
        hsize  = HSIZE_WORD;
        if (hresp)                                   w_next = ST_ERR;
        else if (hready && (r_data_cnt == 2'd3))     w_next = ST_FILL;
      end
      ST_FILL: begin
        line_we = 1'b1;
        w_next  = ST_IDLE;
      end
      ST_ERR: begin
        refill_err = 1'b1;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  icache_line_buf u_line_buf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_data_acc),
    .i_slot  (w_wslot),
    .i_wdata (hrdata),
    .o_line  (line_data)
  );

  assign hwrite     = 1'b0;
  assign crit_valid = r_crit_valid;
  assign crit_data  = r_crit_data;
  assign line_index = r_addr[OFS_W +: INDEX_W];
  assign line_tag   = r_addr[31 -: TAG_W];

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed self-checking bench for icache_refill_ctrl.
module tb_icache_refill_ctrl
  import icache_pkg::*;
;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  miss_valid;
  logic [31:0]           miss_addr;
  logic                  miss_ready;
  logic [31:0]           haddr;
  logic [1:0]            htrans;
  logic [2:0]            hburst;
  logic [2:0]            hsize;
  logic                  hwrite;
  logic                  hready;
  logic                  hresp;
  logic [31:0]           hrdata;
  logic                  crit_valid;
  logic [31:0]           crit_data;
  logic                  line_we;
  logic [INDEX_W-1:0]    line_index;
  logic [TAG_W-1:0]      line_tag;
  logic [CACHE_LINE-1:0] line_data;
  logic                  refill_err;

  int checks = 0;
  int errors = 0;

  icache_refill_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .miss_valid (miss_valid),
    .miss_addr  (miss_addr),
    .miss_ready (miss_ready),
    .haddr      (haddr),
    .htrans     (htrans),
    .hburst     (hburst),
    .hsize      (hsize),
    .hwrite     (hwrite),
    .hready     (hready),
    .hresp      (hresp),
    .hrdata     (hrdata),
    .crit_valid (crit_valid),
    .crit_data  (crit_data),
    .line_we    (line_we),
    .line_index (line_index),
    .line_tag   (line_tag),
    .line_data  (line_data),
    .refill_err (refill_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full refill with hready held high; data for slot s is base+s.
  task automatic refill(input logic [31:0] a, input logic [31:0] base, input bit hold);
    logic [1:0]   s;
    logic [127:0] exp_line;
    miss_valid = 1'b1;
    miss_addr  = a;
    hready     = 1'b1;
    hresp      = 1'b0;
    chk("rf_ready_idle", miss_ready, 1);
    tick();
    if (!hold) miss_valid = 1'b0;
    s = a[1:0];
    chk("rf_htrans0", htrans, HTRANS_NONSEQ);
    chk("rf_haddr0", haddr, {a[29:2], s, 2'b00});
    chk("rf_hburst", hburst, 3'b010);
    chk("rf_hsize", hsize, 3'b010);
    chk("rf_busy", miss_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      s      = a[1:0] + 2'(k - 1);
      hrdata = base + 32'(s);
      if (k < 4) begin
        s = a[1:0] + 2'(k);
        chk("rf_htrans_seq", htrans, HTRANS_SEQ);
        chk("rf_haddr", haddr, {a[29:2], s, 2'b00});
      end else begin
        chk("rf_htrans_end", htrans, HTRANS_IDLE);
      end
      chk("rf_crit_valid", crit_valid, (k == 2));
      if (k == 2) chk("rf_crit_data", crit_data, base + 32'(a[1:0]));
      chk("rf_no_we", line_we, 0);
      chk("rf_busy_k", miss_ready, 0);
    end
    tick();
    exp_line = {base + 32'd3, base + 32'd2, base + 32'd1, base + 32'd0};
    chk("rf_line_we", line_we, 1);
    chk("rf_index", line_index, a[10:2]);
    chk("rf_tag", line_tag, a[31:11]);
    chk("rf_line", line_data, exp_line);
    tick();
    chk("rf_we_off", line_we, 0);
    chk("rf_ready_after", miss_ready, 1);
  endtask

  initial begin
    rst        = 1'b1;
    miss_valid = 1'b0;
    miss_addr  = '0;
    hready     = 1'b1;
    hresp      = 1'b0;
    hrdata     = '0;
    tick();
    tick();
    chk("rst_htrans", htrans, HTRANS_IDLE);
    chk("rst_haddr", haddr, 0);
    chk("rst_hburst", hburst, 0);
    chk("rst_hsize", hsize, 0);
    chk("rst_hwrite", hwrite, 0);
    chk("rst_line_we", line_we, 0);
    chk("rst_crit_valid", crit_valid, 0);
    chk("rst_refill_err", refill_err, 0);
    chk("rst_miss_ready", miss_ready, 1);
    chk("rst_line_data", line_data, 0);
    chk("rst_crit_data", crit_data, 0);
    rst = 1'b0;
    tick();

    // Basic burst, offset 2: 48D8, 48DC, 48D0, 48D4; index 0x08D.
    refill(32'h0000_1236, 32'hD0D0_0000, 1'b0);
    chk("t1_index_const", line_index, 9'h08D);

    // Wait states on beat 1 data phase.
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_1236;
    tick();
    miss_valid = 1'b0;
    chk("t2_haddr0", haddr, 32'h48D8);
    tick();
    hrdata = 32'hE000_0002;
    chk("t2_haddr1", haddr, 32'h48DC);
    tick();
    hready = 1'b0;
    hrdata = 32'h0000_0BAD;
    chk("t2_haddr2", haddr, 32'h48D0);
    chk("t2_crit_valid", crit_valid, 1);
    chk("t2_crit_data", crit_data, 32'hE000_0002);
    tick();
    chk("t2_hold_haddr", haddr, 32'h48D0);
    chk("t2_hold_htrans", htrans, HTRANS_SEQ);
    chk("t2_crit_pulse", crit_valid, 0);
    tick();
    hready = 1'b1;
    hrdata = 32'hE000_0003;
    chk("t2_hold2_haddr", haddr, 32'h48D0);
    chk("t2_hold2_htrans", htrans, HTRANS_SEQ);
    tick();
    hrdata = 32'hE000_0000;
    chk("t2_haddr3", haddr, 32'h48D4);
    chk("t2_no_we_a", line_we, 0);
    tick();
    hrdata = 32'hE000_0001;
    chk("t2_htrans_end", htrans, HTRANS_IDLE);
    chk("t2_no_we_b", line_we, 0);
    tick();
    chk("t2_line_we", line_we, 1);
    chk("t2_line", line_data, {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000});
    tick();
    chk("t2_ready", miss_ready, 1);

    // Bus error on beat 2.
    miss_valid = 1'b1;
    tick();
    miss_valid = 1'b0;
    tick();
    hrdata = 32'hF000_0002;
    tick();
    hrdata = 32'hF000_0003;
    tick();
    hresp = 1'b1;
    chk("t3_htrans_pre", htrans, HTRANS_SEQ);
    tick();
    hresp = 1'b0;
    chk("t3_htrans_idle", htrans, HTRANS_IDLE);
    chk("t3_err", refill_err, 1);
    chk("t3_no_we", line_we, 0);
    tick();
    chk("t3_err_pulse", refill_err, 0);
    chk("t3_no_we2", line_we, 0);
    chk("t3_ready", miss_ready, 1);

    // Bus error on beat 0 suppresses the critical word.
    miss_valid = 1'b1;
    tick();
    miss_valid = 1'b0;
    tick();
    hresp = 1'b1;
    tick();
    hresp = 1'b0;
    chk("t3b_no_crit", crit_valid, 0);
    chk("t3b_err", refill_err, 1);
    tick();
    chk("t3b_ready", miss_ready, 1);

    // Reset during beat 1.
    miss_valid = 1'b1;
    tick();
    miss_valid = 1'b0;
    tick();
    hrdata = 32'hA000_0002;
    tick();
    rst = 1'b1;
    chk("t4_crit_before", crit_valid, 1);
    tick();
    rst = 1'b0;
    chk("t4_htrans", htrans, HTRANS_IDLE);
    chk("t4_haddr", haddr, 0);
    chk("t4_no_we", line_we, 0);
    chk("t4_no_err", refill_err, 0);
    chk("t4_ready", miss_ready, 1);
    chk("t4_line_clr", line_data, 0);
    chk("t4_crit_clr", crit_data, 0);
    tick();
    chk("t4_no_we2", line_we, 0);
    chk("t4_no_err2", refill_err, 0);
    refill(32'h0000_0001, 32'h1111_0000, 1'b0);

    // miss_valid held high: one burst, next accept right after FILL.
    refill(32'hFFFF_FFFF, 32'h2222_0000, 1'b1);
    refill(32'h0000_1236, 32'h3333_0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 CACHE_LINE, 128, line width in bits (4 x 32-bit words).
REQ-002 CACHE_SIZE, 8192, capacity in bytes; derived INDEX_W = clog2(CACHE_SIZE*8/CACHE_LINE) = 9, OFS_W = 2, TAG_W = 32-INDEX_W-OFS_W = 21.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 miss_valid  input  1  refill request from cache lookup.
REQ-006 miss_addr  input  32  word address, split {tag[TAG_W], index[INDEX_W], offset[2]}.
REQ-007 miss_ready  output  1  request accepted on miss_valid && miss_ready.
REQ-008 haddr  output  32  AHB byte address.
REQ-009 htrans  output  2  AHB transfer type.
REQ-010 hburst  output  3  AHB burst type.
REQ-011 hsize  output  3  AHB transfer size.
REQ-012 hwrite  output  1  AHB write; constant 0.
REQ-013 hready  input  1  AHB ready.
REQ-014 hresp  input  1  AHB response; 1 = ERROR.
REQ-015 hrdata  input  32  AHB read data.
REQ-016 crit_valid  output  1  one-cycle pulse: requested word available.
REQ-017 crit_data  output  32  requested word.
REQ-018 line_we  output  1  one-cycle array write strobe.
REQ-019 line_index  output  INDEX_W  array write index.
REQ-020 line_tag  output  TAG_W  tag to store.
REQ-021 line_data  output  128  assembled line; word w at bits [32w+31:32w].
REQ-022 refill_err  output  1  one-cycle pulse on bus error.

Function
REQ-023 FSM states IDLE, ADDR, BEAT, FILL, ERR; miss_ready=1 only in IDLE; handshake latches miss_addr, goes ADDR.
REQ-024 Burst is WRAP4 (hburst=3'b010), word size (hsize=3'b010), hwrite=0, critical word first: beat k targets word slot (offset+k) mod 4.
REQ-025 haddr = {miss_addr[29:2], slot, 2'b00}; slot wraps 3->0 within the line.
REQ-026 ADDR drives htrans=NONSEQ (2'b10) for beat 0; on hready=1 -> BEAT.
REQ-027 BEAT: htrans=SEQ (2'b11) while addresses issued < 4, else IDLE (2'b00); address/control held stable while hready=0.
REQ-028 Data phase pipelined one cycle behind address phase; each hready=1 data cycle stores hrdata into its slot; after 4th beat -> FILL.
REQ-029 crit_valid=1, crit_data=beat-0 data, exactly one cycle after beat 0 data accepted.
REQ-030 FILL: line_we=1 one cycle with latched index/tag and full line; next state IDLE; earliest next acceptance the cycle after FILL.
REQ-031 hresp=1 in any data phase -> htrans=IDLE next cycle, state ERR; ERR pulses refill_err one cycle, -> IDLE; no line_we; crit_valid suppressed if error on beat 0.
REQ-032 miss_valid while not IDLE ignored, no queuing.
REQ-033 Total latency with hready always 1: accept at cycle 0, line_we at cycle 6.

Reset
REQ-034 rst forces IDLE; htrans=IDLE, haddr=0, hburst=0, hsize=0, hwrite=0, line_we=0, crit_valid=0, refill_err=0, miss_ready=1 the following cycle; line_data, crit_data = 0.
REQ-035 rst mid-burst discards partial line; no line_we, no refill_err.

Structure
REQ-036 Package icache_pkg holds CACHE_LINE, CACHE_SIZE defaults, INDEX_W/TAG_W/OFS_W, HTRANS/HBURST/HSIZE encodings, FSM state enum.
REQ-037 One sub-module icache_line_buf: 4x32 word buffer with 2-bit slot write port and 128-bit output.

Verification
REQ-038 miss_addr=0x0000_1236, hready=1 -> haddr 0x48D8,0x48DC,0x48D0,0x48D4; NONSEQ,SEQ,SEQ,SEQ; line_we at cycle 6, index 0x08D, slot2 data = crit_data.
REQ-039 Same request, hready low 2 cycles on beat 1 -> haddr/htrans held; line identical; line_we delayed 2 cycles.
REQ-040 hresp=1 on beat 2 -> htrans IDLE next cycle, refill_err one pulse, no line_we, miss_ready=1 after.
REQ-041 rst asserted during beat 1 -> htrans=IDLE next cycle, no line_we/refill_err; new miss accepted normally.
REQ-042 miss_valid held high across refill -> exactly one burst per acceptance; second accepted cycle after FILL.
